// File: rtl/game_io_pkg.sv
// game_io_pkg: colour codes and event-word layout shared by the button queue and LED-flash logic.
package game_io_pkg;
    localparam logic [1:0] COLOR_RED    = 2'd0;
    localparam logic [1:0] COLOR_BLUE   = 2'd1;
    localparam logic [1:0] COLOR_GREEN  = 2'd2;
    localparam logic [1:0] COLOR_YELLOW = 2'd3;
    localparam int EVT_VALID_BIT = 0;
    localparam int EVT_COLOR_LSB = 1;
    localparam int EVT_OVF_BIT   = 3;
    function automatic logic [31:0] evt_word(input logic valid, input logic [1:0] color, input logic ovf);
        logic [31:0] w;
        w = '0;
        w[EVT_VALID_BIT] = valid;
        w[EVT_COLOR_LSB +: 2] = color;
        w[EVT_OVF_BIT] = ovf;
        return w;
    endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer plus stability counter; pulses press_o on the edge where
// the debounced level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync_q;
    logic stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic s;
    assign s = sync_q[1];
    always_comb begin
        stable_d = stable_q;
        cnt_d = '0;
        if (s != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = s;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    // Pulse coincides with the edge that updates stable, so the FIFO write lands on that same edge.
    assign press_o = stable_d & ~stable_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            stable_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            stable_q <= stable_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/button_event_queue.sv
// button_event_queue: debounces four buttons and queues prioritised press colours for CPU loads.
// Define BUTTON_QUEUE_OVERFLOW_EN to add the sticky overflow flag on event_word bit 3.
module button_event_queue
    import game_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     red_button,
    input  logic                     blue_button,
    input  logic                     green_button,
    input  logic                     yellow_button,
    input  logic                     read_strobe,
    output logic [31:0]              event_word,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0] raw, press;
    logic push_req, push, pop, ovf;
    logic [1:0] push_color;
    logic [1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    assign raw = {yellow_button, green_button, blue_button, red_button};
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_db
            button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clock   (clock),
                .reset   (reset),
                .raw_i   (raw[i]),
                .press_o (press[i])
            );
        end
    endgenerate
    assign push_req = |press;
    assign push_color = press[0] ? COLOR_RED : press[1] ? COLOR_BLUE : press[2] ? COLOR_GREEN : COLOR_YELLOW;
    assign empty = count_q == '0;
    assign full = count_q == (AW+1)'(DEPTH);
    assign count = count_q;
    assign pop = read_strobe & ~empty;
    // A pop frees the slot for a same-cycle push even when full.
    assign push = push_req & (~full | pop);
    always_comb begin
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= push_color;
    end
`ifdef BUTTON_QUEUE_OVERFLOW_EN
    logic ovf_q, ovf_d;
    assign ovf_d = (read_strobe & empty) ? 1'b0 : (push_req & full & ~pop) ? 1'b1 : ovf_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
    assign event_word = evt_word(~empty, empty ? 2'b00 : mem_q[rd_q], ovf);
endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue: table vectors, corner sequences and random traffic checked against a
// window-based behavioural model of debounce, priority and FIFO.
module tb_button_event_queue;
    localparam int DB = 4;
    localparam int DEPTH = 4;
    localparam int LAT = DB + 2;
`ifdef BUTTON_QUEUE_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic red_button = 0, blue_button = 0, green_button = 0, yellow_button = 0, read_strobe = 0;
    logic [31:0] event_word;
    logic empty, full;
    logic [2:0] count;
    int tests = 0, fails = 0;

    button_event_queue #(.DEBOUNCE_CYCLES(DB), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .red_button    (red_button),
        .blue_button   (blue_button),
        .green_button  (green_button),
        .yellow_button (yellow_button),
        .read_strobe   (read_strobe),
        .event_word    (event_word),
        .empty         (empty),
        .full          (full),
        .count         (count)
    );

    always #5 clock = ~clock;

    // Model: raw sample history per button (bit 0 = newest); a level change is accepted when the
    // synchronized value differed from stable over the last DB edges.
    logic [15:0] hist [4];
    bit stab [4];
    logic [1:0] fq [$];
    bit ovf;

    typedef struct {
        logic [3:0] btn;
        logic rd;
        int cyc;
        logic [31:0] word;
        int cnt;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        w = (fq.size() > 0) ? {29'b0, fq[0], 1'b1} : 32'h0;
        if (OVF_EN && ovf) w[3] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0;
            stab[i] = 1'b0;
        end
        fq.delete();
        ovf = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] b, input logic rd);
        int evt, n;
        bit diff, p;
        evt = -1;
        for (int i = 0; i < 4; i++) begin
            hist[i] = {hist[i][14:0], b[i]};
            diff = 1'b1;
            for (int j = 0; j < DB; j++) if (hist[i][2+j] == stab[i]) diff = 1'b0;
            if (diff) begin
                stab[i] = !stab[i];
                if (stab[i] && evt < 0) evt = i;
            end
        end
        n = fq.size();
        p = rd && n > 0;
        if (p) void'(fq.pop_front());
        if (evt >= 0) begin
            if (n < DEPTH || p) fq.push_back(2'(evt));
            else ovf = 1'b1;
        end
        if (rd && n == 0) ovf = 1'b0;
    endtask

    task automatic check_model();
        check("word_vs_model", event_word, exp_word());
        check("count_vs_model", 32'(count), 32'(fq.size()));
        check("empty_vs_model", 32'(empty), 32'(fq.size() == 0));
        check("full_vs_model", 32'(full), 32'(fq.size() == DEPTH));
    endtask

    // Called at a negedge; drives inputs for the next posedge, then returns at the following negedge.
    task automatic step(input logic [3:0] b, input logic rd);
        {yellow_button, green_button, blue_button, red_button} = b;
        read_strobe = rd;
        model_edge(b, rd);
        @(posedge clock);
        #1;
        check_model();
        @(negedge clock);
    endtask

    task automatic press(input logic [3:0] b);
        for (int n = 0; n < LAT; n++) step(b, 1'b0);
        for (int n = 0; n < LAT; n++) step(4'b0, 1'b0);
    endtask

    task automatic add(input logic [3:0] b, input logic rd, input int cyc, input logic [31:0] w, input int c);
        vec_t v;
        v.btn = b; v.rd = rd; v.cyc = cyc; v.word = w; v.cnt = c;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rb;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        check("reset_word", event_word, 32'h0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        reset = 1'b0;

        add(4'b0000, 0, 8, 32'h0, 0);
        add(4'b0100, 0, LAT, 32'h5, 1);
        add(4'b0000, 0, LAT, 32'h5, 1);
        add(4'b0000, 1, 1, 32'h0, 0);
        add(4'b0000, 1, 1, 32'h0, 0);
        add(4'b1010, 0, LAT, 32'h3, 1);
        add(4'b0000, 0, LAT, 32'h3, 1);
        add(4'b0001, 0, LAT, 32'h3, 2);
        add(4'b0000, 0, LAT, 32'h3, 2);
        add(4'b0000, 1, 1, 32'h1, 1);
        add(4'b1000, 1, LAT, 32'h7, 1);
        add(4'b0000, 0, LAT, 32'h7, 1);
        add(4'b0000, 1, 1, 32'h0, 0);
        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].cyc; c++) step(tbl[k].btn, tbl[k].rd && c == 0);
            check($sformatf("tbl%0d_word", k), event_word, tbl[k].word);
            check($sformatf("tbl%0d_count", k), 32'(count), 32'(tbl[k].cnt));
        end

        // Bounce: 2 high / 1 low three times never completes a window.
        for (int r = 0; r < 3; r++) begin
            step(4'b0001, 0);
            step(4'b0001, 0);
            step(4'b0000, 0);
        end
        for (int n = 0; n < LAT - 1; n++) step(4'b0001, 0);
        check("bounce_early", 32'(count), 32'd0);
        step(4'b0001, 0);
        check("bounce_word", event_word, 32'h1);
        check("bounce_count", 32'(count), 32'd1);
        for (int n = 0; n < LAT; n++) step(4'b0000, 0);
        step(4'b0000, 1);
        check("bounce_drain", event_word, 32'h0);

        // Overflow: five presses, no reads.
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000); press(4'b0001);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_read%0d", i), event_word, 32'(2 * i + 1) | (OVF_EN ? 32'h8 : 32'h0));
            step(4'b0000, 1);
        end
        check("ovf_empty_read", event_word, OVF_EN ? 32'h8 : 32'h0);
        step(4'b0000, 1);
        check("ovf_cleared", event_word, 32'h0);

        // Full FIFO: press event and pop on the same edge.
        press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
        for (int n = 0; n < LAT - 1; n++) step(4'b0100, 0);
        step(4'b0100, 1);
        check("pp_count", 32'(count), 32'd4);
        check("pp_head", event_word, 32'h3);
        for (int n = 0; n < LAT; n++) step(4'b0000, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_read%0d", i), event_word, (i == 3) ? 32'h5 : 32'(2 * i + 3));
            step(4'b0000, 1);
        end
        check("pp_empty", 32'(empty), 32'd1);

        // Reset with queued entries while red is held.
        press(4'b0010); press(4'b0100);
        step(4'b0001, 0);
        step(4'b0001, 0);
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_word", event_word, 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < LAT - 1; n++) step(4'b0001, 0);
        check("rst_early", 32'(count), 32'd0);
        step(4'b0001, 0);
        check("rst_press_word", event_word, 32'h1);
        check("rst_press_count", 32'(count), 32'd1);
        for (int n = 0; n < LAT; n++) step(4'b0000, 0);

        // Random traffic, including occasional resets.
        rb = 4'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                #1;
                check("rand_rst_count", 32'(count), 32'd0);
                model_reset();
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
            end
            step(rb, $urandom_range(0, 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_event_queue.md
# button_event_queue

Debounces the four game buttons, converts each debounced press into a colour code, and queues the codes in a small FIFO for the processor to read. It sits directly upstream of the memory-mapped button read path: the top level drives `read_strobe` on every load from the button address and returns `event_word` as load data. Because the word format matches the LED-flash store format, software can store a read word to the LED address unchanged to echo the press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `red_button` in 1: raw, asynchronous, active-high.
- `blue_button` in 1: as above.
- `green_button` in 1: as above.
- `yellow_button` in 1: as above.
- `read_strobe` in 1: pop request; high for one cycle per load.
- `event_word` out 32: head entry, combinational. Bit 0 = valid; bits [2:1] = colour; bit 3 = overflow flag (see Configuration); bits [31:4] = 0.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Colour codes: red 00, blue 01, green 10, yellow 11.
- Per button:
  - 2-flop synchronizer produces `s`.
  - Debounce counter: any cycle with `s == stable` clears it; otherwise it increments.
  - When the counter is at `DEBOUNCE_CYCLES-1` and `s != stable`, `stable` takes `s` at that edge and the counter clears.
  - A press event is the rising transition of `stable`. Releases generate no event.
- Simultaneous press events in one cycle: fixed priority red > blue > green > yellow. Only the highest-priority event is enqueued; the others are discarded.
- Push: a press event enqueues `{valid=1, colour}` when not full.
- Push while full: without a same-cycle pop, the event is dropped and the sticky overflow bit is set.
- Pop: `read_strobe` with `!empty` advances the head.
- `read_strobe` while empty: no state change. `event_word` is `0` that cycle, apart from bit 3.
- Push and pop in the same cycle:
  - Full: both occur, `count` is unchanged, and no overflow.
  - Empty: the pop is ignored, the push lands, and the load sees `0`.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally. `count` is tracked separately.

## Timing
- Reset (asynchronous) state:
  - Sync flops, `stable`, counters and pointers all 0.
  - `count` = 0, `empty` = 1, `full` = 0, `event_word` = 0, overflow = 0.
- `event_word`, `empty`, `full` and `count` are combinational from registered state only. They never depend on `read_strobe`, so load data is valid in the same cycle as the strobe.
- Press latency: raw input first sampled high at edge k and held → `stable` rises and the entry is written at edge k+1+DEBOUNCE_CYCLES → visible on `event_word` after that edge.
- A bounce (`s` returning to `stable` for one cycle) restarts the full debounce window.
- Button held across reset deassertion: `stable` restarts at 0, so exactly one press event is generated one debounce window after release of reset.
- Reset asserted mid-debounce or with a non-empty FIFO: all state is cleared immediately and queued events are lost.

## Configuration
- `BUTTON_QUEUE_OVERFLOW_EN` defined:
  - Sticky overflow register is implemented and drives `event_word[3]` on every read, including empty reads.
  - The register clears on the cycle a `read_strobe` occurs while `empty` is 1, and on reset.
- Not defined:
  - `event_word[3]` is tied to 0 and no overflow register exists.
  - Dropped events remain silently discarded.

## Structure
- Shared package `game_io_pkg`:
  - Colour localparams `COLOR_RED`, `COLOR_BLUE`, `COLOR_GREEN`, `COLOR_YELLOW`.
  - Word bit positions `EVT_VALID_BIT`, `EVT_COLOR_LSB`, `EVT_OVF_BIT`.
  - The same constants are used by the LED-flash logic.
- Sub-module `button_debounce`: synchronizer, counter and `stable` register, with an output pulse on rising `stable`. Instantiated four times.
- FIFO, priority select and overflow logic are in the top of this block.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `DEPTH=4`.
- Clean press: `green_button` high from edge 10 → entry visible after edge 15; `event_word`=0x5, `count`=1; a `read_strobe` then gives `empty`=1 and `event_word`=0x0.
- Bounce: `red_button` toggles high 2 cycles / low 1 cycle ×3, then holds high → exactly one event 0x1, appearing 5 edges after the final rise is sampled.
- Simultaneous: `blue_button` and `yellow_button` rise on the same edge → one entry 0x3; `count`=1.
- Overflow: five presses with no reads → `full`=1, `count`=4, 5th dropped. Reads return 0x1, 0x3, 0x5, 0x7 in press order, each with bit 3 set when the macro is defined. A 5th read returns 0x8, then 0x0 after that empty read.
- Full push+pop: FIFO full, press event and `read_strobe` on the same cycle → `count` stays 4 and the new entry is at the tail.
- Reset mid-operation: 2 entries queued, `reset` pulsed for 1 cycle while `red_button` is held → immediately `count`=0, `event_word`=0; one 0x1 event appears 5 edges after reset release.
